// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem requests, branch pre-decode,
// next-PC selection from the predictor's answer, and mispredict redirects.
module fetch_unit #(
  parameter int          IMM_WIDTH = 12,
  parameter logic [6:0]  BR_OPCODE = 7'b1100011,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  output logic                 imem_req_o,
  output logic [31:0]          imem_addr_o,
  input  logic                 imem_rvalid_i,
  input  logic [31:0]          imem_rdata_i,
  output logic [31:0]          program_counter_o,
  output logic [IMM_WIDTH-1:0] br_imm_o,
  output logic                 issuing_branch_o,
  input  logic [31:0]          program_counter_branched_i,
  input  logic                 br_taken_i,
  output logic                 iq_valid_o,
  input  logic                 iq_ready_i,
  output logic [31:0]          iq_instr_o,
  output logic [31:0]          iq_pc_o,
  output logic                 iq_pred_taken_o,
  input  logic                 redirect_i,
  input  logic [31:0]          redirect_pc_i
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_ISSUE, S_DRAIN} state_e;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  state_e      state_q, state_d;
  logic [31:0] pc_q, buf_instr, buf_pc;
  logic        is_branch, handshake;

  assign is_branch = (buf_instr[6:0] == BR_OPCODE);
  // A redirect kills the handshake so the queue never sees a wrong-path instruction.
  assign handshake = (state_q == S_ISSUE) && iq_ready_i && !redirect_i;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= S_REQ;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ:   state_d = redirect_i ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (redirect_i)         state_d = imem_rvalid_i ? S_REQ : S_DRAIN;
        else if (imem_rvalid_i) state_d = S_ISSUE;
      end
      S_ISSUE: if (redirect_i || iq_ready_i) state_d = S_REQ;
      S_DRAIN: if (imem_rvalid_i) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pc_q      <= RESET_PC;
      buf_instr <= '0;
      buf_pc    <= '0;
    end else begin
      // PC stays word aligned whatever the source.
      if (redirect_i)
        pc_q <= redirect_pc_i & WORD_MASK;
      else if (handshake)
        pc_q <= (is_branch && br_taken_i) ? (program_counter_branched_i & WORD_MASK)
                                          : buf_pc + 32'd4;
      if (state_q == S_WAIT && imem_rvalid_i && !redirect_i) begin
        buf_instr <= imem_rdata_i;
        buf_pc    <= pc_q;
      end
    end
  end

  // Outputs are forced quiet while reset is held, including the REQ strobe.
  always_comb begin
    imem_req_o        = 1'b0;
    imem_addr_o       = '0;
    program_counter_o = '0;
    br_imm_o          = '0;
    issuing_branch_o  = 1'b0;
    iq_valid_o        = 1'b0;
    iq_instr_o        = '0;
    iq_pc_o           = '0;
    iq_pred_taken_o   = 1'b0;
    if (reset_ni) begin
      imem_req_o        = (state_q == S_REQ);
      imem_addr_o       = pc_q;
      program_counter_o = buf_pc;
      br_imm_o          = buf_instr[31 -: IMM_WIDTH];
      issuing_branch_o  = handshake && is_branch;
      iq_valid_o        = (state_q == S_ISSUE) && !redirect_i;
      iq_instr_o        = buf_instr;
      iq_pc_o           = buf_pc;
      iq_pred_taken_o   = is_branch && br_taken_i;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, branches, stall, redirects,
// PC wrap and mid-flight reset, checked with immediate assertions.
module tb_fetch_unit;
  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] program_counter_o;
  logic [11:0] br_imm_o;
  logic        issuing_branch_o;
  logic [31:0] program_counter_branched_i;
  logic        br_taken_i;
  logic        iq_valid_o;
  logic        iq_ready_i;
  logic [31:0] iq_instr_o;
  logic [31:0] iq_pc_o;
  logic        iq_pred_taken_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  int nvec = 0;
  int nerr = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] BR0 = 32'hABC0_0063;
  localparam logic [31:0] BR1 = 32'h1230_0063;

  always #5 clk_i = ~clk_i;

  fetch_unit dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .program_counter_o(program_counter_o), .br_imm_o(br_imm_o),
    .issuing_branch_o(issuing_branch_o),
    .program_counter_branched_i(program_counter_branched_i), .br_taken_i(br_taken_i),
    .iq_valid_o(iq_valid_o), .iq_ready_i(iq_ready_i),
    .iq_instr_o(iq_instr_o), .iq_pc_o(iq_pc_o), .iq_pred_taken_o(iq_pred_taken_o),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req"}, 32'(imem_req_o), 0);
    chk({tag, "_addr"}, imem_addr_o, 0);
    chk({tag, "_vld"}, 32'(iq_valid_o), 0);
    chk({tag, "_ibr"}, 32'(issuing_branch_o), 0);
    chk({tag, "_pt"}, 32'(iq_pred_taken_o), 0);
    chk({tag, "_imm"}, 32'(br_imm_o), 0);
    chk({tag, "_pc"}, program_counter_o, 0);
    chk({tag, "_iqpc"}, iq_pc_o, 0);
    chk({tag, "_iqin"}, iq_instr_o, 0);
  endtask

  // Entered and left at a negedge with the DUT in REQ; 1-cycle memory, ready=1.
  task automatic fetch(input logic [31:0] a, input logic [31:0] ins,
                       input logic tk, input logic [31:0] tgt);
    logic br;
    br = (ins[6:0] == 7'b1100011);
    #1 chk("req", 32'(imem_req_o), 1);
    chk("req_addr", imem_addr_o, a);
    chk("req_novld", 32'(iq_valid_o), 0);
    @(negedge clk_i); imem_rvalid_i = 1'b1; imem_rdata_i = ins;
    #1 chk("wait_noreq", 32'(imem_req_o), 0);
    chk("wait_novld", 32'(iq_valid_o), 0);
    @(negedge clk_i); imem_rvalid_i = 1'b0; iq_ready_i = 1'b1;
    br_taken_i = tk; program_counter_branched_i = tgt;
    #1 chk("iss_vld", 32'(iq_valid_o), 1);
    chk("iss_pc", iq_pc_o, a);
    chk("iss_prpc", program_counter_o, a);
    chk("iss_instr", iq_instr_o, ins);
    chk("iss_imm", 32'(br_imm_o), 32'(ins[31:20]));
    chk("iss_ibr", 32'(issuing_branch_o), 32'(br));
    chk("iss_pt", 32'(iq_pred_taken_o), 32'(br & tk));
    @(negedge clk_i);
  endtask

  initial begin
    reset_ni = 1'b1; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    program_counter_branched_i = '0; br_taken_i = 1'b0; iq_ready_i = 1'b1;
    redirect_i = 1'b0; redirect_pc_i = '0;
    #2 reset_ni = 1'b0;
    #1 chk_quiet("rst");
    repeat (3) @(negedge clk_i);
    chk_quiet("rst_hold");
    reset_ni = 1'b1;

    // Sequential non-branch fetch from RESET_PC
    fetch(32'h00, NOP, 1'b0, 32'h0);
    fetch(32'h04, 32'h0040_0093, 1'b0, 32'h0);
    fetch(32'h08, 32'h0080_0113, 1'b0, 32'h0);
    fetch(32'h0C, NOP, 1'b1, 32'h80);   // taken ignored for non-branch
    // Branch taken to 0x40, then back to 0x10, then not taken
    fetch(32'h10, BR0, 1'b1, 32'h40);
    fetch(32'h40, BR0, 1'b1, 32'h10);
    fetch(32'h10, BR0, 1'b0, 32'h40);

    // Stall 5 cycles in ISSUE at 0x14, handshake on the 6th
    #1 chk("st_req", 32'(imem_req_o), 1);
    chk("st_addr", imem_addr_o, 32'h14);
    @(negedge clk_i); imem_rvalid_i = 1'b1; imem_rdata_i = BR1;
    @(negedge clk_i); imem_rvalid_i = 1'b0; iq_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      br_taken_i = i[0];
      #1 chk("st_vld", 32'(iq_valid_o), 1);
      chk("st_instr", iq_instr_o, BR1);
      chk("st_pc", iq_pc_o, 32'h14);
      chk("st_noreq", 32'(imem_req_o), 0);
      chk("st_noibr", 32'(issuing_branch_o), 0);
      chk("st_pt", 32'(iq_pred_taken_o), 32'(i[0]));
      @(negedge clk_i);
    end
    iq_ready_i = 1'b1; br_taken_i = 1'b0; program_counter_branched_i = 32'h99C;
    #1 chk("st_hs_vld", 32'(iq_valid_o), 1);
    chk("st_hs_ibr", 32'(issuing_branch_o), 1);
    chk("st_hs_imm", 32'(br_imm_o), 32'h123);
    @(negedge clk_i);

    // Redirect in WAIT, response arrives next cycle and is dropped
    #1 chk("rw_addr", imem_addr_o, 32'h18);
    @(negedge clk_i); redirect_i = 1'b1; redirect_pc_i = 32'h203;
    #1 chk("rw_novld", 32'(iq_valid_o), 0);
    @(negedge clk_i); redirect_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = NOP;
    #1 chk("rw_drain_noreq", 32'(imem_req_o), 0);
    chk("rw_drain_novld", 32'(iq_valid_o), 0);
    @(negedge clk_i); imem_rvalid_i = 1'b0;
    #1 chk("rw_req", 32'(imem_req_o), 1);
    chk("rw_addr2", imem_addr_o, 32'h200);
    chk("rw_novld2", 32'(iq_valid_o), 0);

    // Redirect colliding with a ready handshake of a taken branch at 0x200
    @(negedge clk_i); imem_rvalid_i = 1'b1; imem_rdata_i = BR0;
    @(negedge clk_i); imem_rvalid_i = 1'b0; iq_ready_i = 1'b1;
    br_taken_i = 1'b1; program_counter_branched_i = 32'h80;
    redirect_i = 1'b1; redirect_pc_i = 32'h300;
    #1 chk("ri_novld", 32'(iq_valid_o), 0);
    chk("ri_noibr", 32'(issuing_branch_o), 0);
    @(negedge clk_i); redirect_i = 1'b0; br_taken_i = 1'b0;
    fetch(32'h300, NOP, 1'b0, 32'h0);

    // Redirect in REQ: request still issued, then drained
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
    #1 chk("rq_req", 32'(imem_req_o), 1);
    chk("rq_addr", imem_addr_o, 32'h304);
    @(negedge clk_i); redirect_i = 1'b0;
    #1 chk("rq_drain_noreq", 32'(imem_req_o), 0);
    @(negedge clk_i); imem_rvalid_i = 1'b1; imem_rdata_i = BR0;
    #1 chk("rq_drain_novld", 32'(iq_valid_o), 0);
    @(negedge clk_i); imem_rvalid_i = 1'b0;

    // PC wrap, then reset mid-WAIT
    fetch(32'hFFFF_FFFC, NOP, 1'b0, 32'h0);
    fetch(32'h0000_0000, NOP, 1'b0, 32'h0);
    #1 chk("mr_addr", imem_addr_o, 32'h4);
    @(negedge clk_i); reset_ni = 1'b0;
    #1 chk_quiet("mr");
    @(negedge clk_i); reset_ni = 1'b1;
    fetch(32'h0, 32'h00C0_0193, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the global correlating branch predictor and the instruction queue. It holds the PC, issues single-outstanding requests to instruction memory, and pre-decodes branches. It sends PC, immediate and the issue strobe to the predictor, and picks the next PC from its taken/target answer. It also accepts mispredict redirects from the branch ALU.

Parameters:
IMM_WIDTH, 12, branch immediate width; immediate is instr[31 -: IMM_WIDTH]
BR_OPCODE, 7'b1100011, opcode (instr[6:0]) identifying a conditional branch
RESET_PC, 32'h0000_0000, PC fetched first after reset

Ports:
clk_i  in  1  system clock
reset_ni  in  1  asynchronous active-low reset
imem_req_o  out  1  fetch request, one-cycle pulse
imem_addr_o  out  32  fetch address (word32_t)
imem_rvalid_i  in  1  response valid
imem_rdata_i  in  32  response instruction
program_counter_o  out  32  PC of buffered instruction, to predictor
br_imm_o  out  IMM_WIDTH  raw immediate of buffered instruction, to predictor
issuing_branch_o  out  1  branch accepted by queue this cycle, to predictor
program_counter_branched_i  in  32  predicted branch target from predictor
br_taken_i  in  1  prediction from predictor, combinational
iq_valid_o  out  1  instruction available to queue
iq_ready_i  in  1  queue can accept
iq_instr_o  out  32  instruction
iq_pc_o  out  32  instruction PC
iq_pred_taken_o  out  1  is_branch & br_taken_i
redirect_i  in  1  mispredict redirect from branch ALU
redirect_pc_i  in  32  correct PC

Behaviour:
- State machine: REQ, WAIT, ISSUE, DRAIN. Registers: pc_q, buf_instr, buf_pc.
- Reset (async, reset_ni=0): state=REQ, pc_q=RESET_PC, buf_instr=0, buf_pc=0. All outputs 0 while in reset. After release, the first REQ cycle drives imem_req_o=1 with addr RESET_PC.
- REQ: imem_req_o=1, imem_addr_o=pc_q. Next state WAIT.
- WAIT: imem_req_o=0. On imem_rvalid_i, load buf_instr=imem_rdata_i and buf_pc=pc_q, then go to ISSUE. Otherwise stay in WAIT (no timeout).
- ISSUE: iq_valid_o=1. iq_instr_o=buf_instr and iq_pc_o=program_counter_o=buf_pc. br_imm_o=buf_instr[31 -: IMM_WIDTH], driven in every state.
- is_branch = (buf_instr[6:0]==BR_OPCODE).
- Handshake at iq_valid_o & iq_ready_i:
  - issuing_branch_o = is_branch. This is a one-cycle pulse, 0 otherwise.
  - pc_q = (is_branch & br_taken_i) ? program_counter_branched_i : buf_pc+4.
  - Next state REQ.
- Stall: in ISSUE with iq_ready_i=0, hold the state. iq_instr_o and iq_pc_o stay stable. iq_pred_taken_o may change, because the predictor can update history while stalled; the queue samples it only at handshake.
- Throughput: 3 cycles per instruction with 1-cycle memory (REQ t, rvalid t+1, handshake t+2).
- PC arithmetic: modulo 2^32. 32'hFFFF_FFFC+4 = 0. pc_q[1:0] is always 0; redirect_pc_i[1:0] is ignored (forced to 0).
- Redirect (highest priority, any state):
  - pc_q = {redirect_pc_i[31:2],2'b00}.
  - iq_valid_o and issuing_branch_o are gated to 0 in the redirect cycle, so no handshake occurs.
  - From REQ: the request issued this cycle is outstanding, so go to DRAIN.
  - From WAIT: with imem_rvalid_i high the same cycle, discard the response and go to REQ; otherwise go to DRAIN.
  - From ISSUE: discard the buffer and go to REQ.
  - From DRAIN: stay in DRAIN with the new pc_q, or go to REQ if imem_rvalid_i is high the same cycle.
- DRAIN: imem_req_o=0. Wait for imem_rvalid_i, discard the data, then go to REQ. Never more than one outstanding request.

Test Plan:
- Reset, then release with RESET_PC=0 and rvalid one cycle after req, ready=1, non-branch words: imem_addr_o pulses 0,4,8 every 3 cycles, and iq_pc_o/iq_instr_o match each address.
- Branch at PC 0x10, br_taken_i=1, program_counter_branched_i=0x40: issuing_branch_o pulses once, iq_pred_taken_o=1, next imem_addr_o=0x40. Same with br_taken_i=0: next addr 0x14, iq_pred_taken_o=0.
- iq_ready_i=0 for 5 cycles in ISSUE: iq_valid_o held, payload stable, no imem_req_o, no issuing_branch_o. Handshake on the 6th cycle.
- redirect_i with redirect_pc_i=0x203 in WAIT, response arriving the next cycle: response dropped (no iq_valid_o), then next req addr=0x200.
- redirect_i in the same cycle as a ready handshake of a branch: no iq handshake, issuing_branch_o=0, next req addr=redirect PC.
- pc_q=0xFFFF_FFFC, non-branch accepted: next imem_addr_o=0x0000_0000. Assert reset_ni mid-WAIT: outputs 0 immediately, and the restart fetches RESET_PC.
